ahbl_dma_master: RTL and testbench
==================================

Name: ahbl_dma_master

Overview:
- AHB-Lite initiator that copies a block of 32-bit words from a source address to a destination address.
- Second bus master for the Hazard2 SoC, used where the CPU is the usual initiator. It drives HADDR/HTRANS/HSIZE/HWRITE/HWDATA into the same splitter/slave fabric (ROM, RAM, GPIO).
- Configuration arrives on direct sideband ports. There is no register slave in this block.
- Transfers are strictly serial: one read, then one write, per word.

Parameters:
CNT_W, 16, width of the word-count input; maximum transfer is 2^CNT_W-1 words

Ports:
HCLK  in  1  bus clock
HRESET  in  1  asynchronous, active-high reset
start  in  1  single-cycle request; sampled only in IDLE
src_addr  in  32  source byte address; bits [1:0] ignored (forced 00)
dst_addr  in  32  destination byte address; bits [1:0] ignored (forced 00)
word_cnt  in  CNT_W  number of words to copy
busy  out  1  high from the cycle after start is accepted until DONE is left
done  out  1  one-cycle pulse when the block completes
HADDR  out  32  AHB address
HTRANS  out  2  AHB transfer type; only IDLE (00) and NONSEQ (10) are used
HSIZE  out  3  constant 3'b010 (word)
HWRITE  out  1  AHB write strobe
HWDATA  out  32  AHB write data
HREADY  in  1  bus ready (muxed HREADYOUT from the splitter)
HRDATA  in  32  bus read data

Behaviour:
- Reset values (asynchronous on HRESET=1):
  - state=IDLE, HADDR=0, HTRANS=00, HWRITE=0, HWDATA=0, busy=0, done=0.
  - Internal src/dst/count/buffer registers = 0.
- All outputs are registered.
- State machine states: IDLE, RD_A, RD_D, WR_A, WR_D, FIN.
- IDLE:
  - start=1 with word_cnt!=0: latch {src_addr[31:2],2'b00}, {dst_addr[31:2],2'b00} and word_cnt, then go to RD_A.
  - start=1 with word_cnt=0: go directly to FIN. No bus activity.
  - start=0: stay in IDLE.
- RD_A:
  - Drive HADDR=src, HTRANS=NONSEQ, HWRITE=0.
  - If HREADY=0, hold every address-phase signal unchanged.
  - If HREADY=1, go to RD_D and drive HTRANS=IDLE for the following cycle.
- RD_D:
  - Wait for HREADY=1, then capture HRDATA into the buffer and go to WR_A.
  - HRDATA is ignored while HREADY=0.
- WR_A:
  - Drive HADDR=dst, HTRANS=NONSEQ, HWRITE=1.
  - Hold signals while HREADY=0. On HREADY=1, go to WR_D.
- WR_D:
  - Drive HWDATA=buffer, HTRANS=IDLE, HWRITE=0.
  - HWDATA stays stable until HREADY=1.
  - On HREADY=1: src+=4, dst+=4 (32-bit wrap, 0xFFFFFFFC→0x00000000), count-=1.
  - Next state: FIN if the new count is 0, otherwise RD_A.
- FIN: done=1 for exactly this cycle, busy=0 next cycle, return to IDLE.
- busy=1 in RD_A, RD_D, WR_A, WR_D and FIN.
- start while busy: ignored. It is neither queued nor changes the latched config.
- Latency:
  - Zero-wait-state bus: 4 cycles per word.
  - First NONSEQ appears 1 cycle after start is sampled.
  - done pulses 1 cycle after the final write data phase completes.
- Wait states: every HREADY=0 cycle extends the current phase by exactly 1 cycle. Protocol signals never change mid-wait.
- Address phase of the next transfer always follows completion of the previous data phase. The block never has two outstanding transfers.
- Reset mid-transfer: the bus returns immediately to HTRANS=IDLE. The partially completed word is lost and there is no done pulse.
- Unmapped addresses: the bus returns 0xBADDBEEF, which is copied like any other data. There is no error response.

Decomposition:
- Shared package ahbl_pkg holds:
  - HTRANS_IDLE=2'b00, HTRANS_NONSEQ=2'b10
  - HSIZE_WORD=3'b010
  - dma_state_t enum {IDLE, RD_A, RD_D, WR_A, WR_D, FIN}
- No sub-module. A single FSM plus datapath registers is the natural size.

Test Plan:
1. Copy 4 words, RAM 0x20000000→0x20000100, HREADY tied to 1 → writes 0x20000100..0x2000010C match the source; done pulses at cycle 17 after start; busy spans 17 cycles.
2. Same copy, slave inserts 2 wait states on every data phase → data is correct; HADDR/HTRANS/HWDATA are stable during waits; total is 4×(4+4)+1=33 cycles.
3. start with word_cnt=0 → no NONSEQ ever appears; done pulses 1 cycle after start; busy is high for 1 cycle.
4. Unaligned start, src=0x00000003, dst=0x20000006 → first HADDR values are 0x00000000 (ROM read) and 0x20000004 (write).
5. Second start, src=0x0, pulsed while busy → ignored; the original addresses complete; only one done pulse.
6. HRESET asserted during the WR_D of word 2 of 5 → same cycle: HTRANS=00, busy=0, no done. After release, a new start with word_cnt=1 copies correctly.

Source files
------------

// File: rtl/ahbl_pkg.sv
// Shared AHB-Lite encodings and the DMA master's state type.
// Imported by the DMA master and anything else that speaks to the same fabric.
package ahbl_pkg;

   localparam logic [1:0]  HTRANS_IDLE   = 2'b00;
   localparam logic [1:0]  HTRANS_NONSEQ = 2'b10;
   localparam logic [2:0]  HSIZE_WORD    = 3'b010;
   localparam logic [31:0] WORD_BYTES    = 32'd4;

   typedef enum logic [2:0] {
      IDLE,
      RD_A,
      RD_D,
      WR_A,
      WR_D,
      FIN
   } dma_state_t;

   // The copy engine only moves whole words, so the byte lane bits are dropped.
   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/ahbl_dma_master.sv
// AHB-Lite block copy initiator: one read then one write per word, never two
// transfers outstanding, configured from sideband ports.
module ahbl_dma_master
   import ahbl_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             HCLK,
   input  logic             HRESET,
   input  logic             start,
   input  logic [31:0]      src_addr,
   input  logic [31:0]      dst_addr,
   input  logic [CNT_W-1:0] word_cnt,
   output logic             busy,
   output logic             done,
   output logic [31:0]      HADDR,
   output logic [1:0]       HTRANS,
   output logic [2:0]       HSIZE,
   output logic             HWRITE,
   output logic [31:0]      HWDATA,
   input  logic             HREADY,
   input  logic [31:0]      HRDATA
);

   dma_state_t       state;
   logic [31:0]      src;
   logic [31:0]      dst;
   logic [CNT_W-1:0] count;
   logic [31:0]      buffer;

   assign HSIZE = HSIZE_WORD;

   // Every bus signal is registered and only moves when HREADY completes the
   // current phase, so wait states freeze the whole protocol view.
   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         state  <= IDLE;
         src    <= '0;
         dst    <= '0;
         count  <= '0;
         buffer <= '0;
         HADDR  <= '0;
         HTRANS <= HTRANS_IDLE;
         HWRITE <= 1'b0;
         HWDATA <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  busy <= 1'b1;
                  if (word_cnt != '0) begin
                     src    <= word_align(src_addr);
                     dst    <= word_align(dst_addr);
                     count  <= word_cnt;
                     HADDR  <= word_align(src_addr);
                     HTRANS <= HTRANS_NONSEQ;
                     HWRITE <= 1'b0;
                     state  <= RD_A;
                  end else begin
                     done  <= 1'b1;
                     state <= FIN;
                  end
               end
            end

            RD_A: begin
               if (HREADY) begin
                  HTRANS <= HTRANS_IDLE;
                  state  <= RD_D;
               end
            end

            RD_D: begin
               if (HREADY) begin
                  buffer <= HRDATA;
                  HADDR  <= dst;
                  HTRANS <= HTRANS_NONSEQ;
                  HWRITE <= 1'b1;
                  state  <= WR_A;
               end
            end

            WR_A: begin
               if (HREADY) begin
                  HTRANS <= HTRANS_IDLE;
                  HWRITE <= 1'b0;
                  HWDATA <= buffer;
                  state  <= WR_D;
               end
            end

            // Addresses wrap naturally at 32 bits; the last word ends in FIN.
            WR_D: begin
               if (HREADY) begin
                  src   <= src + WORD_BYTES;
                  dst   <= dst + WORD_BYTES;
                  count <= count - CNT_W'(1);
                  if (count == CNT_W'(1)) begin
                     done  <= 1'b1;
                     state <= FIN;
                  end else begin
                     HADDR  <= src + WORD_BYTES;
                     HTRANS <= HTRANS_NONSEQ;
                     state  <= RD_A;
                  end
               end
            end

            FIN: begin
               busy  <= 1'b0;
               state <= IDLE;
            end

            default: begin
               HTRANS <= HTRANS_IDLE;
               HWRITE <= 1'b0;
               busy   <= 1'b0;
               state  <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ahbl_dma_master.sv
// Self-checking bench for ahbl_dma_master: a behavioural AHB slave with
// memory plus a word-list reference model of the copy.
module tb_ahbl_dma_master;

   localparam int CNT_W = 16;

   logic             HCLK = 1'b0;
   logic             HRESET = 1'b1;
   logic             start = 1'b0;
   logic [31:0]      src_addr = '0;
   logic [31:0]      dst_addr = '0;
   logic [CNT_W-1:0] word_cnt = '0;
   logic             busy;
   logic             done;
   logic [31:0]      HADDR;
   logic [1:0]       HTRANS;
   logic [2:0]       HSIZE;
   logic             HWRITE;
   logic [31:0]      HWDATA;
   logic             HREADY = 1'b1;
   logic [31:0]      HRDATA = '0;

   int checks = 0;
   int passed = 0;

   ahbl_dma_master #(.CNT_W(CNT_W)) dut (
      .HCLK(HCLK), .HRESET(HRESET), .start(start),
      .src_addr(src_addr), .dst_addr(dst_addr), .word_cnt(word_cnt),
      .busy(busy), .done(done),
      .HADDR(HADDR), .HTRANS(HTRANS), .HSIZE(HSIZE), .HWRITE(HWRITE),
      .HWDATA(HWDATA), .HREADY(HREADY), .HRDATA(HRDATA)
   );

   always #5 HCLK = ~HCLK;

   logic [31:0] mem [logic [31:0]];
   logic [32:0] acc_q[$];
   logic [31:0] wr_data_q[$];
   int cyc = 0, start_cyc = 0, done_cyc = -1;
   int done_cnt = 0, busy_cycles = 0, nonseq_cnt = 0, stab_err = 0;
   int data_waits = 0;
   bit addr_stall = 1'b0;
   bit dp_valid = 1'b0, dp_write = 1'b0, prev_hold = 1'b0;
   int dp_wait = 0;
   logic [31:0] dp_addr, s_addr, s_wdata;
   logic [1:0]  s_trans;
   logic        s_write;

   function automatic logic [31:0] read_mem(input logic [31:0] a);
      return mem.exists(a) ? mem[a] : 32'hBADDBEEF;
   endfunction

   // Slave model: acts once per cycle at the falling edge, between DUT updates.
   initial begin
      forever begin
         @(negedge HCLK);
         cyc++;
         if (HRESET) begin
            dp_valid  = 1'b0;
            prev_hold = 1'b0;
            HREADY    = 1'b1;
         end else begin
            if (prev_hold && (HADDR !== s_addr || HTRANS !== s_trans ||
                              HWRITE !== s_write || HWDATA !== s_wdata))
               stab_err++;
            if (busy) busy_cycles++;
            if (done) begin
               done_cnt++;
               done_cyc = cyc;
            end
            if (dp_valid) begin
               if (dp_wait > 0) begin
                  HREADY = 1'b0;
                  HRDATA = $urandom;
                  dp_wait--;
               end else begin
                  HREADY   = 1'b1;
                  dp_valid = 1'b0;
                  if (dp_write) begin
                     wr_data_q.push_back(HWDATA);
                     mem[dp_addr] = HWDATA;
                  end else begin
                     HRDATA = read_mem(dp_addr);
                  end
               end
            end else begin
               HREADY = (addr_stall && $urandom_range(0, 2) == 0) ? 1'b0 : 1'b1;
            end
            if (HREADY && HTRANS == 2'b10) begin
               nonseq_cnt++;
               acc_q.push_back({HWRITE, HADDR});
               dp_valid = 1'b1;
               dp_addr  = HADDR;
               dp_write = HWRITE;
               dp_wait  = data_waits;
            end
            prev_hold = !HREADY && busy;
            s_addr = HADDR; s_trans = HTRANS; s_write = HWRITE; s_wdata = HWDATA;
         end
      end
   end

   task automatic clear_logs();
      acc_q.delete();
      wr_data_q.delete();
      stab_err = 0; done_cnt = 0; busy_cycles = 0; nonseq_cnt = 0; done_cyc = -1;
   endtask

   task automatic launch(input logic [31:0] s, input logic [31:0] d, input logic [CNT_W-1:0] n);
      @(negedge HCLK); #1;
      src_addr = s; dst_addr = d; word_cnt = n; start = 1'b1;
      start_cyc = cyc;
      @(negedge HCLK); #1;
      start = 1'b0;
      src_addr = $urandom; dst_addr = $urandom; word_cnt = CNT_W'($urandom);
   endtask

   task automatic wait_done(input int budget, output bit timed_out);
      timed_out = 1'b1;
      for (int i = 0; i < budget; i++) begin
         if (done_cnt > 0) begin
            timed_out = 1'b0;
            break;
         end
         @(negedge HCLK); #1;
      end
      repeat (3) begin
         @(negedge HCLK); #1;
      end
   endtask

   // One full copy compared against the word-list model; exp_cycles < 0 skips timing.
   task automatic run_copy(input string tag, input logic [31:0] s, input logic [31:0] d,
                           input int n, input int waits, input bit stall, input int exp_cycles);
      bit to;
      int bad;
      logic [32:0] exp_acc[$];
      logic [31:0] exp_wd[$];
      logic [31:0] sa, da;
      sa = s & ~32'h3;
      da = d & ~32'h3;
      for (int i = 0; i < n; i++) begin
         exp_acc.push_back({1'b0, sa + 32'(4 * i)});
         exp_acc.push_back({1'b1, da + 32'(4 * i)});
         exp_wd.push_back(read_mem(sa + 32'(4 * i)));
      end
      data_waits = waits;
      addr_stall = stall;
      clear_logs();
      launch(s, d, CNT_W'(n));
      wait_done(40 * n + 20, to);

      checks++;
      if (to) $display("[TB] FAIL %s timeout: done never seen", tag);
      else passed++;
      checks++;
      if (done_cnt !== 1) $display("[TB] FAIL %s done_count: got %0d want 1", tag, done_cnt);
      else passed++;

      bad = 0;
      if (acc_q.size() != exp_acc.size()) bad = 1;
      else foreach (exp_acc[i]) if (acc_q[i] !== exp_acc[i]) bad++;
      checks++;
      if (bad !== 0)
         $display("[TB] FAIL %s addr_seq: got %0d transfers first=%h want %0d first=%h", tag,
                  acc_q.size(), (acc_q.size() > 0) ? acc_q[0] : 33'h0, exp_acc.size(), exp_acc[0]);
      else passed++;

      bad = 0;
      if (wr_data_q.size() != exp_wd.size()) bad = 1;
      else foreach (exp_wd[i]) if (wr_data_q[i] !== exp_wd[i]) bad++;
      checks++;
      if (bad !== 0)
         $display("[TB] FAIL %s write_data: got %0d words first=%h want %0d first=%h", tag,
                  wr_data_q.size(), (wr_data_q.size() > 0) ? wr_data_q[0] : 32'h0,
                  exp_wd.size(), exp_wd[0]);
      else passed++;

      checks++;
      if (stab_err !== 0) $display("[TB] FAIL %s wait_stability: got %0d changes want 0", tag, stab_err);
      else passed++;

      if (exp_cycles >= 0) begin
         checks++;
         if (busy_cycles !== exp_cycles)
            $display("[TB] FAIL %s busy_cycles: got %0d want %0d", tag, busy_cycles, exp_cycles);
         else passed++;
         checks++;
         if (done_cyc - start_cyc !== exp_cycles)
            $display("[TB] FAIL %s done_latency: got %0d want %0d", tag, done_cyc - start_cyc, exp_cycles);
         else passed++;
      end
      data_waits = 0;
      addr_stall = 1'b0;
   endtask

   task automatic test_reset();
      HRESET = 1'b1;
      repeat (2) @(negedge HCLK);
      #1;
      checks++;
      if (HTRANS !== 2'b00 || HWRITE !== 1'b0)
         $display("[TB] FAIL reset_trans: got %b/%b want 00/0", HTRANS, HWRITE);
      else passed++;
      checks++;
      if (HADDR !== 32'h0 || HWDATA !== 32'h0)
         $display("[TB] FAIL reset_bus: got %h/%h want 0/0", HADDR, HWDATA);
      else passed++;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0)
         $display("[TB] FAIL reset_status: got busy=%b done=%b want 0/0", busy, done);
      else passed++;
      checks++;
      if (HSIZE !== 3'b010) $display("[TB] FAIL hsize: got %b want 010", HSIZE);
      else passed++;
      HRESET = 1'b0;
      @(negedge HCLK); #1;
   endtask

   task automatic test_copy_zero_wait();
      run_copy("zero_wait", 32'h2000_0000, 32'h2000_0100, 4, 0, 1'b0, 17);
   endtask

   task automatic test_wait_states();
      run_copy("wait2", 32'h2000_0000, 32'h2000_0100, 4, 2, 1'b0, 33);
   endtask

   task automatic test_zero_count();
      clear_logs();
      launch(32'h2000_0000, 32'h2000_0100, '0);
      repeat (6) begin
         @(negedge HCLK); #1;
      end
      checks++;
      if (nonseq_cnt !== 0) $display("[TB] FAIL zero_nonseq: got %0d want 0", nonseq_cnt);
      else passed++;
      checks++;
      if (done_cnt !== 1 || done_cyc - start_cyc !== 1)
         $display("[TB] FAIL zero_done: got count=%0d latency=%0d want 1/1", done_cnt, done_cyc - start_cyc);
      else passed++;
      checks++;
      if (busy_cycles !== 1) $display("[TB] FAIL zero_busy: got %0d want 1", busy_cycles);
      else passed++;
   endtask

   task automatic test_unaligned();
      run_copy("unaligned", 32'h0000_0003, 32'h2000_0006, 2, 0, 1'b0, 9);
      checks++;
      if (acc_q.size() < 2 || acc_q[0] !== {1'b0, 32'h0000_0000} || acc_q[1] !== {1'b1, 32'h2000_0004})
         $display("[TB] FAIL unaligned_first: got %h want read 0 then write 20000004",
                  (acc_q.size() > 0) ? acc_q[0] : 33'h0);
      else passed++;
   endtask

   task automatic test_wrap_unmapped();
      run_copy("wrap", 32'h3000_0000, 32'hFFFF_FFF8, 3, 1, 1'b0, 19);
      checks++;
      if (wr_data_q.size() < 1 || wr_data_q[0] !== 32'hBADDBEEF)
         $display("[TB] FAIL unmapped_data: got %h want baddbeef",
                  (wr_data_q.size() > 0) ? wr_data_q[0] : 32'h0);
      else passed++;
   endtask

   task automatic test_start_while_busy();
      bit to;
      int bad;
      logic [32:0] exp_acc[$];
      for (int i = 0; i < 3; i++) begin
         exp_acc.push_back({1'b0, 32'h2000_0040 + 32'(4 * i)});
         exp_acc.push_back({1'b1, 32'h2000_0200 + 32'(4 * i)});
      end
      clear_logs();
      launch(32'h2000_0040, 32'h2000_0200, 3);
      repeat (3) begin
         @(negedge HCLK); #1;
      end
      src_addr = 32'h0; dst_addr = 32'h2000_0300; word_cnt = 5; start = 1'b1;
      @(negedge HCLK); #1;
      start = 1'b0;
      wait_done(100, to);
      repeat (10) begin
         @(negedge HCLK); #1;
      end
      checks++;
      if (to || done_cnt !== 1) $display("[TB] FAIL busy_start_done: got %0d pulses want 1", done_cnt);
      else passed++;
      checks++;
      if (nonseq_cnt !== 6) $display("[TB] FAIL busy_start_transfers: got %0d want 6", nonseq_cnt);
      else passed++;
      bad = 0;
      if (acc_q.size() != exp_acc.size()) bad = 1;
      else foreach (exp_acc[i]) if (acc_q[i] !== exp_acc[i]) bad++;
      checks++;
      if (bad !== 0)
         $display("[TB] FAIL busy_start_addrs: got %0d transfers first=%h want first=%h",
                  acc_q.size(), (acc_q.size() > 0) ? acc_q[0] : 33'h0, exp_acc[0]);
      else passed++;
   endtask

   task automatic test_reset_mid_transfer();
      int guard;
      clear_logs();
      launch(32'h2000_0000, 32'h2000_0600, 5);
      guard = 0;
      while (acc_q.size() < 4 && guard < 50) begin
         @(negedge HCLK); #1;
         guard++;
      end
      checks++;
      if (acc_q.size() < 4) $display("[TB] FAIL midreset_reach: got %0d transfers want 4", acc_q.size());
      else passed++;
      @(negedge HCLK); #2;
      HRESET = 1'b1;
      #1;
      checks++;
      if (HTRANS !== 2'b00 || busy !== 1'b0 || done !== 1'b0)
         $display("[TB] FAIL midreset_immediate: got trans=%b busy=%b done=%b want 00/0/0", HTRANS, busy, done);
      else passed++;
      checks++;
      if (HADDR !== 32'h0 || HWDATA !== 32'h0)
         $display("[TB] FAIL midreset_bus: got %h/%h want 0/0", HADDR, HWDATA);
      else passed++;
      repeat (2) @(negedge HCLK);
      #1;
      HRESET = 1'b0;
      clear_logs();
      repeat (6) begin
         @(negedge HCLK); #1;
      end
      checks++;
      if (done_cnt !== 0 || nonseq_cnt !== 0)
         $display("[TB] FAIL midreset_quiet: got done=%0d transfers=%0d want 0/0", done_cnt, nonseq_cnt);
      else passed++;
      run_copy("after_reset", 32'h2000_0080, 32'h2000_0500, 1, 0, 1'b0, 5);
   endtask

   task automatic test_random();
      for (int it = 0; it < 6; it++) begin
         logic [31:0] s, d;
         int n, w;
         bit st;
         s  = 32'h2000_0000 + 32'(4 * $urandom_range(0, 40)) + 32'($urandom_range(0, 3));
         d  = 32'h2000_0400 + 32'(4 * $urandom_range(0, 64)) + 32'($urandom_range(0, 3));
         n  = $urandom_range(1, 6);
         w  = $urandom_range(0, 2);
         st = 1'($urandom_range(0, 1));
         run_copy($sformatf("random%0d", it), s, d, n, w, st, st ? -1 : n * (4 + 2 * w) + 1);
      end
   endtask

   initial begin
      #400000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      for (int i = 0; i < 64; i++) mem[32'h2000_0000 + 32'(4 * i)] = $urandom;
      for (int i = 0; i < 16; i++) mem[32'(4 * i)] = $urandom;
      test_reset();
      test_copy_zero_wait();
      test_wait_states();
      test_zero_count();
      test_unaligned();
      test_wrap_unmapped();
      test_start_while_busy();
      test_reset_mid_transfer();
      test_random();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
